// File: rtl/sseg_scan_driver.sv
// Time-multiplexed seven-segment driver: scans DIGITS hex digits with a
// double-buffered value that only changes at frame boundaries.
module sseg_scan_driver #(
  parameter int DIGITS           = 4,
  parameter int REFRESH_DIV      = 50000,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit CATHODE_INVERT   = 1'b0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   Num,
  input  logic [DIGITS-1:0]     Dp,
  input  logic                  LzBlank,
  output logic [DIGITS-1:0]     Anode,
  output logic [7:0]            Cathode,
  output logic                  Pending,
  output logic                  FrameTick
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IW-1:0]     LAST_IDX     = IW'(DIGITS - 1);
  localparam logic [PW-1:0]     LAST_PRESC   = PW'(REFRESH_DIV - 1);
  localparam logic [DIGITS-1:0] ANODE_OFF    = ANODE_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7:0]        CATHODE_MASK = CATHODE_INVERT ? 8'hFF : 8'h00;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      4'hF: hex_to_seg = 7'h71;
      default: hex_to_seg = 7'h00;
    endcase
  endfunction

  logic [PW-1:0]       presc_r, presc_nxt_s;
  logic [IW-1:0]       idx_r, idx_nxt_s;
  logic [4*DIGITS-1:0] pend_num_r, pend_num_nxt_s, act_num_r, act_num_nxt_s;
  logic [DIGITS-1:0]   pend_dp_r, pend_dp_nxt_s, act_dp_r, act_dp_nxt_s;
  logic                pending_r, pending_nxt_s;
  logic [DIGITS-1:0]   anode_r, anode_nxt_s, onehot_s;
  logic [7:0]          cathode_r, cathode_nxt_s;
  logic                frametick_r;
  logic                wrap_s, boundary_s, higher_nz_s, blank_s;
  logic [3:0]          digit_s;
  logic [6:0]          seg_s;

  assign wrap_s     = Enable && (presc_r == LAST_PRESC);
  assign boundary_s = wrap_s && (idx_r == LAST_IDX);

  // Scan counters and double-buffer next state
  always_comb begin
    presc_nxt_s    = presc_r;
    idx_nxt_s      = idx_r;
    act_num_nxt_s  = act_num_r;
    act_dp_nxt_s   = act_dp_r;
    pend_num_nxt_s = pend_num_r;
    pend_dp_nxt_s  = pend_dp_r;
    pending_nxt_s  = pending_r;
    if (wrap_s) begin
      presc_nxt_s = '0;
      idx_nxt_s   = (idx_r == LAST_IDX) ? '0 : idx_r + IW'(1);
    end else if (Enable) begin
      presc_nxt_s = presc_r + PW'(1);
    end else begin
      presc_nxt_s = presc_r;
    end
    // A load landing on the boundary bypasses the pending buffer entirely
    if (boundary_s) begin
      pending_nxt_s = 1'b0;
      if (Load) begin
        act_num_nxt_s = Num;
        act_dp_nxt_s  = Dp;
      end else if (pending_r) begin
        act_num_nxt_s = pend_num_r;
        act_dp_nxt_s  = pend_dp_r;
      end else begin
        act_num_nxt_s = act_num_r;
      end
    end else if (Load) begin
      pend_num_nxt_s = Num;
      pend_dp_nxt_s  = Dp;
      pending_nxt_s  = 1'b1;
    end else begin
      pending_nxt_s = pending_r;
    end
  end

  // Output decode from next-state values so outputs track the index without skew
  always_comb begin
    digit_s     = act_num_nxt_s[{idx_nxt_s, 2'b00} +: 4];
    higher_nz_s = 1'b0;
    onehot_s    = '0;
    for (int j = 0; j < DIGITS; j++) begin
      if ((IW'(j) >= idx_nxt_s) && (act_num_nxt_s[4*j +: 4] != 4'h0)) begin
        higher_nz_s = 1'b1;
      end else begin
        higher_nz_s = higher_nz_s;
      end
      onehot_s[j] = Enable && (idx_nxt_s == IW'(j));
    end
    blank_s = LzBlank && (idx_nxt_s != '0) && !higher_nz_s;
    seg_s   = blank_s ? 7'h00 : hex_to_seg(digit_s);
    if (Enable) begin
      anode_nxt_s   = ANODE_ACTIVE_LOW ? ~onehot_s : onehot_s;
      cathode_nxt_s = {act_dp_nxt_s[idx_nxt_s], seg_s} ^ CATHODE_MASK;
    end else begin
      anode_nxt_s   = ANODE_OFF;
      cathode_nxt_s = CATHODE_MASK;
    end
  end

  // State and registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      presc_r     <= '0;
      idx_r       <= '0;
      pend_num_r  <= '0;
      pend_dp_r   <= '0;
      act_num_r   <= '0;
      act_dp_r    <= '0;
      pending_r   <= 1'b0;
      anode_r     <= ANODE_OFF;
      cathode_r   <= CATHODE_MASK;
      frametick_r <= 1'b0;
    end else begin
      presc_r     <= presc_nxt_s;
      idx_r       <= idx_nxt_s;
      pend_num_r  <= pend_num_nxt_s;
      pend_dp_r   <= pend_dp_nxt_s;
      act_num_r   <= act_num_nxt_s;
      act_dp_r    <= act_dp_nxt_s;
      pending_r   <= pending_nxt_s;
      anode_r     <= anode_nxt_s;
      cathode_r   <= cathode_nxt_s;
      frametick_r <= boundary_s;
    end
  end

  assign Anode     = anode_r;
  assign Cathode   = cathode_r;
  assign Pending   = pending_r;
  assign FrameTick = frametick_r;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Scoreboard bench for sseg_scan_driver: a cycle-count reference model pushes
// expected outputs per edge; a negedge monitor pops and compares.
module tb_sseg_scan_driver;

  localparam int D = 4;
  localparam int R = 2;

  logic        Clk = 1'b0;
  logic        Reset, Enable, Load, LzBlank;
  logic [15:0] Num;
  logic [3:0]  Dp;
  logic [3:0]  Anode;
  logic [7:0]  Cathode;
  logic        Pending, FrameTick;

  always #5 Clk = ~Clk;

  sseg_scan_driver #(
    .DIGITS(D), .REFRESH_DIV(R), .ANODE_ACTIVE_LOW(1'b1), .CATHODE_INVERT(1'b0)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .Load(Load), .Num(Num), .Dp(Dp),
    .LzBlank(LzBlank), .Anode(Anode), .Cathode(Cathode), .Pending(Pending),
    .FrameTick(FrameTick)
  );

  typedef struct {
    logic [3:0] an;
    logic [7:0] cat;
    logic       pend;
    logic       ft;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: n counts enabled edges since reset
  int          n = 0;
  logic [15:0] act_num = 16'h0, pend_num = 16'h0;
  logic [3:0]  act_dp = 4'h0, pend_dp = 4'h0;
  bit          pend_flag = 1'b0;

  task automatic drive(input bit rst, input bit en, input bit ld,
                       input logic [15:0] num, input logic [3:0] dp, input bit lz);
    exp_t        e;
    bit          bnd;
    bit          blank;
    int          d;
    logic [3:0]  digit;
    logic [3:0]  one;
    Reset = rst; Enable = en; Load = ld; Num = num; Dp = dp; LzBlank = lz;
    one = 4'b0001;
    bnd = 1'b0;
    if (rst) begin
      n = 0; act_num = 16'h0; act_dp = 4'h0; pend_num = 16'h0; pend_dp = 4'h0;
      pend_flag = 1'b0;
      e.an = 4'hF; e.cat = 8'h00; e.pend = 1'b0; e.ft = 1'b0;
    end else begin
      if (en) begin
        n++;
        bnd = ((n % (D * R)) == 0);
      end
      if (bnd) begin
        if (ld) begin
          act_num = num; act_dp = dp;
        end else if (pend_flag) begin
          act_num = pend_num; act_dp = pend_dp;
        end
        pend_flag = 1'b0;
      end else if (ld) begin
        pend_num = num; pend_dp = dp; pend_flag = 1'b1;
      end
      if (en) begin
        d     = (n / R) % D;
        digit = 4'((act_num >> (4 * d)) & 16'h000F);
        blank = lz && (d > 0) && ((act_num >> (4 * d)) == 16'h0);
        e.an  = ~(one << d);
        e.cat = {act_dp[d], blank ? 7'h00 : seg_tab[digit]};
        e.ft  = bnd;
      end else begin
        e.an = 4'hF; e.cat = 8'h00; e.ft = 1'b0;
      end
      e.pend = pend_flag;
    end
    sb_q.push_back(e);
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int cycles, input bit lz);
    for (int i = 0; i < cycles; i++) drive(1'b0, 1'b1, 1'b0, 16'h0, 4'h0, lz);
  endtask

  // Monitor: one expected entry per clock edge
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        vectors++;
        if (Anode !== e.an || Cathode !== e.cat || Pending !== e.pend || FrameTick !== e.ft) begin
          miscompares++;
          $display("FAIL outputs vec %0d: got an=%b cat=%b pend=%b ft=%b, expected an=%b cat=%b pend=%b ft=%b",
                   vectors, Anode, Cathode, Pending, FrameTick, e.an, e.cat, e.pend, e.ft);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    idle(3, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 16'h0126, 4'h0, 1'b0);
    idle(20, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 16'h0060, 4'b0100, 1'b1);
    idle(20, 1'b1);
    // Double load mid-frame: latest value wins at the boundary
    while ((n % (D * R)) != 2) idle(1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 16'h1111, 4'h0, 1'b0);
    idle(2, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 16'h2222, 4'h0, 1'b0);
    idle(10, 1'b0);
    // Load exactly on the boundary edge
    while ((n % (D * R)) != (D * R - 1)) idle(1, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 16'h3333, 4'hA, 1'b0);
    idle(4, 1'b0);
    // Enable dropped mid-digit
    while ((n % R) != 1) idle(1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    idle(6, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 16'hABCD, 4'h5, 1'b0);
    idle(3, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    idle(3, 1'b0);
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 100) == 0, ($urandom % 8) != 0, ($urandom % 6) == 0,
            16'($urandom), 4'($urandom), 1'($urandom));
    end
    idle(2, 1'b0);
    @(negedge Clk);
    @(negedge Clk);
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
